// File: rtl/wb_copy_master.sv
// wb_copy_master: word-by-word memory copy engine.
// Pipelined Wishbone B4 master with one request outstanding at a time.
module wb_copy_master #(
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_adr_i,
    input  logic [ADDR_WIDTH-1:0] dst_adr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [31:0]           wb_dat_o,
    input  logic [31:0]           wb_dat_i,
    input  logic                  wb_ack_i,
    input  logic                  wb_stall_i,
    input  logic                  wb_err_i
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        FINISH
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src;
    logic [ADDR_WIDTH-1:0] r_dst;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_count;
    logic [31:0]           r_data;
    logic [TW-1:0]         r_wait;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_we;
    logic [3:0]            r_sel;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic w_timeout;
    logic w_fail;
    logic w_last;

    // An ack landing on the final wait cycle still wins over the timeout.
    assign w_timeout = (r_wait == TW'(TIMEOUT - 1)) && !wb_ack_i;
    assign w_fail    = wb_err_i || w_timeout;
    assign w_last    = (r_count + 1'b1) == r_len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_wait  <= '0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_adr   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len_i != '0) begin
                            r_src   <= src_adr_i;
                            r_dst   <= dst_adr_i;
                            r_len   <= len_i;
                            r_count <= '0;
                            r_cyc   <= 1'b1;
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_sel   <= 4'hF;
                            r_adr   <= src_adr_i;
                            r_state <= RD_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end
                    end
                end
                RD_REQ: begin
                    if (!wb_stall_i) begin
                        r_stb   <= 1'b0;
                        r_wait  <= '0;
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (w_fail) begin
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else if (wb_ack_i) begin
                        r_data  <= wb_dat_i;
                        r_src   <= r_src + 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_adr   <= r_dst;
                        r_state <= WR_REQ;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                WR_REQ: begin
                    if (!wb_stall_i) begin
                        r_stb   <= 1'b0;
                        r_wait  <= '0;
                        r_state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (w_fail) begin
                        r_err   <= 1'b1;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FINISH;
                    end else if (wb_ack_i) begin
                        r_dst   <= r_dst + 1'b1;
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_cyc   <= 1'b0;
                            r_we    <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_stb   <= 1'b1;
                            r_we    <= 1'b0;
                            r_adr   <= r_src;
                            r_state <= RD_REQ;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign err_o    = r_err;
    assign count_o  = r_count;
    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_stb;
    assign wb_we_o  = r_we;
    assign wb_sel_o = r_sel;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_data;

endmodule
